modq_reduce_pipe: RTL and testbench
===================================

MODQ_REDUCE_PIPE -- requirements
Module: modq_reduce_pipe

Interface
REQ-001 SHALL have parameter Q, default 5167: odd modulus, 3 <= Q < 2^15.
REQ-002 SHALL have parameter IN_W, default 34: signed input width per lane, 16..48.
REQ-003 SHALL have parameter LANES, default 1: number of independent lanes, 1..8.
REQ-004 SHALL have local parameter OUT_W = clog2(Q)+1, giving a signed output width per lane.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port In, input, LANES*IN_W bits: lane k occupies bits [k*IN_W +: IN_W], two's complement.
REQ-008 SHALL have port InValid, input, 1 bit: In holds a beat this cycle.
REQ-009 SHALL have port InReady, output, 1 bit: the pipeline accepts a beat this cycle.
REQ-010 SHALL have port Out, output, LANES*OUT_W bits: lane k occupies bits [k*OUT_W +: OUT_W], two's complement.
REQ-011 SHALL have port OutValid, output, 1 bit: Out holds a result.
REQ-012 SHALL have port OutReady, input, 1 bit: the consumer takes Out this cycle.

Function
REQ-013 SHALL compute, per lane, r = In mod Q with a remainder congruent to In (mod Q), using exact integer arithmetic with no overflow for any IN_W-bit input.
REQ-014 SHALL be a fixed 3-stage pipeline: stage 1 folds the high bits against precomputed 2^j mod Q constants, stage 2 folds again to fewer than clog2(Q)+3 bits, stage 3 applies the final conditional ±Q correction and registers Out.
REQ-015 SHALL accept a beat when InValid && InReady; its result SHALL appear on Out with OutValid=1 exactly 3 cycles later if no stall occurs.
REQ-016 SHALL drive InReady = !(OutValid && !OutReady), a combinational function of the output-stage state only.
REQ-017 SHALL hold every stage (data and valid) unchanged while OutValid && !OutReady; Out SHALL be stable during the stall and no beat SHALL be lost or duplicated.
REQ-018 SHALL carry one valid bit per stage; a bubble (InValid=0) SHALL propagate as a valid=0 stage, and data registers SHALL be don't-care when their valid bit is 0.
REQ-019 SHALL sustain one beat per cycle when OutReady is held at 1.
REQ-020 SHALL process all lanes in lockstep under the shared handshake.

Reset
REQ-021 SHALL clear all stage valid bits and OutValid to 0, and Out to 0, immediately on Reset=1, without waiting for a clock edge.
REQ-022 SHALL discard any beat in flight when Reset asserts mid-stream; the first beat after reset release SHALL produce its result 3 cycles after acceptance.
REQ-023 SHALL drive InReady=1 while Reset is 1 and on the first cycle after release.

Configuration
REQ-024 SHALL, when macro MODQ_CENTERED_OUT_EN is defined, produce outputs in the centered range [-(Q-1)/2, (Q-1)/2].
REQ-025 SHALL, when MODQ_CENTERED_OUT_EN is undefined, produce outputs in the range [0, Q-1] with the sign bit always 0.
REQ-026 SHALL keep latency and handshake identical in both configurations; only the stage-3 correction logic differs.

Structure
REQ-027 SHALL place clog2, the fold-constant generation function, and the lane-slice width constants in shared package modq_pkg.
REQ-028 SHALL instantiate sub-module modq_fold_lane once per lane for the datapath; valid and stall control SHALL be shared in the top level.

Verification
REQ-029 SHALL cover, with Q=5167, IN_W=34, LANES=1, centered: In=5167 -> Out=0; In=2584 -> Out=-2583; In=2583 -> Out=2583; In=-1 -> Out=-1.
REQ-030 SHALL cover extremes, centered: In=2^33-1 -> Out=-1396; In=-2^33 -> Out=1395.
REQ-031 SHALL cover the non-centered configuration: In=-1 -> Out=5166; In=2^33-1 -> Out=3771; In=-2^33 -> Out=1395.
REQ-032 SHALL cover backpressure: stream In=0,1,2,... with OutReady toggling at random -> outputs appear in order with no gaps or repeats, and Out stays stable while stalled.
REQ-033 SHALL cover reset mid-stream: assert Reset while 3 beats are in flight -> OutValid=0 at once, and no stale result appears after release.
REQ-034 SHALL cover lanes: LANES=4 with lanes fed 5167, -5168, 2^33-1 and 7 -> outputs 0, -1, -1396 and 7 in the same cycle (centered).

Source files
------------

// File: rtl/modq_pkg.sv
// Shared helpers for the mod-Q reduction pipeline: clog2, fold constants and per-stage width offsets.
// Used by modq_fold_lane and modq_reduce_pipe; the MODQ_CENTERED_OUT_EN option lives in modq_fold_lane.
package modq_pkg;

  // Bits added above clog2(Q) at each stage so that the partial sums stay exact.
  localparam int unsigned S1_EXTRA = 6;
  localparam int unsigned T_EXTRA  = 3;
  localparam int unsigned S2_EXTRA = 2;
  localparam int unsigned D_EXTRA  = 4;
  localparam int unsigned MAX_MULT = 8;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // 2^j mod q, built by repeated doubling so it never overflows.
  function automatic int unsigned fold_const(input int unsigned q, input int unsigned j);
    int unsigned r;
    r = 1 % q;
    for (int unsigned i = 0; i < j; i++) r = (r * 2) % q;
    return r;
  endfunction

  // Non-negative residue of -2^j, used for the two's complement sign bit.
  function automatic int unsigned neg_const(input int unsigned q, input int unsigned j);
    return (q - fold_const(q, j)) % q;
  endfunction

  function automatic int unsigned out_width(input int unsigned q);
    return clog2(q) + 1;
  endfunction

endpackage

// File: rtl/modq_fold_lane.sv
// One lane of the 3-stage mod-Q reducer: fold, fold again, final correction.
// Define MODQ_CENTERED_OUT_EN for outputs in [-(Q-1)/2, (Q-1)/2]; otherwise [0, Q-1].
module modq_fold_lane import modq_pkg::*; #(
  parameter  int unsigned Q     = 5167,
  parameter  int unsigned IN_W  = 34,
  localparam int unsigned OUT_W = out_width(Q)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] r
);

  localparam int unsigned K    = clog2(Q);
  localparam int unsigned S1_W = K + S1_EXTRA;
  localparam int unsigned T_W  = K + T_EXTRA;
  localparam int unsigned S2_W = K + S2_EXTRA;
  localparam int unsigned D_W  = K + D_EXTRA;
  localparam int unsigned N1   = IN_W - K;
`ifdef MODQ_CENTERED_OUT_EN
  localparam int unsigned OFF  = (Q - 1) / 2;
`else
  localparam int unsigned OFF  = 0;
`endif

  logic [S1_W-1:0]  t1 [N1];
  logic [T_W-1:0]   t2 [S1_EXTRA];
  logic [S2_W-1:0]  t3 [T_EXTRA];
  logic [S1_W-1:0]  s1_c;
  logic [S1_W-1:0]  s1;
  logic [T_W-1:0]   u_c;
  logic [S2_W-1:0]  w_c;
  logic [S2_W-1:0]  s2;
  logic [D_W-1:0]   cand;
  logic [OUT_W-1:0] r_c;

  // Stage 1: every bit at or above K is replaced by its residue; the sign bit carries -2^(IN_W-1).
  for (genvar j = 0; j < N1; j++) begin : g_t1
    localparam int unsigned B = K + j;
    localparam int unsigned C = (B == IN_W - 1) ? neg_const(Q, B) : fold_const(Q, B);
    assign t1[j] = x[B] ? S1_W'(C) : '0;
  end

  always_comb begin
    s1_c = S1_W'(x[K-1:0]);
    for (int i = 0; i < int'(N1); i++) s1_c = s1_c + t1[i];
  end

  // Stage 2: two chained folds bring the value below 2^(K+2).
  for (genvar j = 0; j < S1_EXTRA; j++) begin : g_t2
    localparam int unsigned C = fold_const(Q, K + j);
    assign t2[j] = s1[K+j] ? T_W'(C) : '0;
  end

  always_comb begin
    u_c = T_W'(s1[K-1:0]);
    for (int i = 0; i < int'(S1_EXTRA); i++) u_c = u_c + t2[i];
  end

  for (genvar j = 0; j < T_EXTRA; j++) begin : g_t3
    localparam int unsigned C = fold_const(Q, K + j);
    assign t3[j] = u_c[K+j] ? S2_W'(C) : '0;
  end

  always_comb begin
    w_c = S2_W'(u_c[K-1:0]);
    for (int i = 0; i < int'(T_EXTRA); i++) w_c = w_c + t3[i];
  end

  // Stage 3: s2 < 8Q, so exactly one s2 - m*Q (m = 0..8) lands in the output window.
  always_comb begin
    cand = '0;
    r_c  = '0;
    for (int m = 0; m <= int'(MAX_MULT); m++) begin
      cand = D_W'(s2) - D_W'(m * Q);
      if (D_W'(cand + D_W'(OFF)) < D_W'(Q)) r_c = cand[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      r  <= '0;
    end else if (advance) begin
      s1 <= s1_c;
      s2 <= w_c;
      r  <= r_c;
    end
  end

endmodule

// File: rtl/modq_reduce_pipe.sv
// Multi-lane 3-stage signed mod-Q reduction pipeline with valid/ready flow control.
// Output range selected by MODQ_CENTERED_OUT_EN (see modq_fold_lane).
module modq_reduce_pipe import modq_pkg::*; #(
  parameter  int unsigned Q     = 5167,
  parameter  int unsigned IN_W  = 34,
  parameter  int unsigned LANES = 1,
  localparam int unsigned OUT_W = out_width(Q)
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic [LANES*IN_W-1:0]  In,
  input  logic                   InValid,
  output logic                   InReady,
  output logic [LANES*OUT_W-1:0] Out,
  output logic                   OutValid,
  input  logic                   OutReady
);

  logic stall_c;
  logic advance_c;
  logic v1;
  logic v2;

  // The whole pipe freezes only when the output holds a result nobody is taking.
  assign stall_c   = OutValid && !OutReady;
  assign advance_c = !stall_c;
  assign InReady   = advance_c;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      OutValid <= 1'b0;
    end else if (advance_c) begin
      v1       <= InValid;
      v2       <= v1;
      OutValid <= v2;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    modq_fold_lane #(
      .Q    (Q),
      .IN_W (IN_W)
    ) u_lane (
      .clk     (clk),
      .rst     (Reset),
      .advance (advance_c),
      .x       (In[k*IN_W +: IN_W]),
      .r       (Out[k*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_modq_reduce_pipe.sv
// Directed bench for modq_reduce_pipe (Q=5167, IN_W=34, LANES=4); expectations follow MODQ_CENTERED_OUT_EN.
module tb_modq_reduce_pipe;

  localparam int unsigned Q     = 5167;
  localparam int unsigned IN_W  = 34;
  localparam int unsigned LANES = 4;
  localparam int unsigned OUT_W = 14;
  localparam int          N_STR = 40;
  localparam longint      P33M1 = 64'sd8589934591;
  localparam longint      N33   = -64'sd8589934592;
`ifdef MODQ_CENTERED_OUT_EN
  localparam bit CENTERED = 1'b1;
`else
  localparam bit CENTERED = 1'b0;
`endif

  localparam longint VIN [4][4] = '{
    '{64'sd5167, 64'sd2584, 64'sd2583, -64'sd1},
    '{P33M1, N33, -64'sd5168, 64'sd7},
    '{64'sd5167, -64'sd5168, P33M1, 64'sd7},
    '{64'sd0, 64'sd5166, 64'sd10334, -64'sd5167}
  };
  localparam int EXP_C [4][4] = '{
    '{0, -2583, 2583, -1},
    '{-1396, 1395, -1, 7},
    '{0, -1, -1396, 7},
    '{0, -1, 0, 0}
  };
  localparam int EXP_N [4][4] = '{
    '{0, 2584, 2583, 5166},
    '{3771, 1395, 5166, 7},
    '{0, 5166, 3771, 7},
    '{0, 5166, 0, 0}
  };

  logic                   clk = 1'b0;
  logic                   Reset;
  logic [LANES*IN_W-1:0]  In;
  logic                   InValid;
  logic                   InReady;
  logic [LANES*OUT_W-1:0] Out;
  logic                   OutValid;
  logic                   OutReady;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  modq_reduce_pipe #(
    .Q     (Q),
    .IN_W  (IN_W),
    .LANES (LANES)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .In       (In),
    .InValid  (InValid),
    .InReady  (InReady),
    .Out      (Out),
    .OutValid (OutValid),
    .OutReady (OutReady)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LANES*IN_W-1:0] pack_in(input longint a0, input longint a1,
                                                      input longint a2, input longint a3);
    return {IN_W'(a3), IN_W'(a2), IN_W'(a1), IN_W'(a0)};
  endfunction

  function automatic logic [LANES*OUT_W-1:0] pack_out(input int e0, input int e1,
                                                        input int e2, input int e3);
    return {OUT_W'(e3), OUT_W'(e2), OUT_W'(e1), OUT_W'(e0)};
  endfunction

  function automatic logic [LANES*OUT_W-1:0] vec_exp(input int v);
    if (CENTERED) return pack_out(EXP_C[v][0], EXP_C[v][1], EXP_C[v][2], EXP_C[v][3]);
    return pack_out(EXP_N[v][0], EXP_N[v][1], EXP_N[v][2], EXP_N[v][3]);
  endfunction

  // One beat through an idle pipe; result must show up 3 cycles after acceptance.
  task automatic send_one(input int v, input string tag);
    int lat;
    @(negedge clk);
    In       = pack_in(VIN[v][0], VIN[v][1], VIN[v][2], VIN[v][3]);
    InValid  = 1'b1;
    OutReady = 1'b1;
    @(negedge clk);
    InValid = 1'b0;
    lat = 1;
    while (!OutValid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(3));
    check({tag, "_val"}, 64'(Out), 64'(vec_exp(v)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n_sent;
    int  n_got;
    int  cyc;
    int  seen;
    bit  stalled;
    logic [LANES*OUT_W-1:0] held;

    Reset    = 1'b1;
    InValid  = 1'b0;
    OutReady = 1'b1;
    In       = '0;
    #12;
    check("rst_valid", 64'(OutValid), 64'(0));
    check("rst_out", 64'(Out), 64'(0));
    check("rst_ready", 64'(InReady), 64'(1));
    @(negedge clk);
    Reset = 1'b0;
    #1;
    check("ready_after_release", 64'(InReady), 64'(1));

    for (int v = 0; v < 4; v++) send_one(v, $sformatf("vec%0d", v));

    // Reset with three beats in flight.
    @(negedge clk);
    OutReady = 1'b1;
    for (int b = 0; b < 3; b++) begin
      In      = pack_in(100 + b, 200 + b, 300 + b, 400 + b);
      InValid = 1'b1;
      @(negedge clk);
    end
    InValid  = 1'b0;
    OutReady = 1'b0;
    check("inflight_valid", 64'(OutValid), 64'(1));
    check("inflight_val", 64'(Out), 64'(pack_out(100, 200, 300, 400)));
    Reset = 1'b1;
    #1;
    check("async_rst_valid", 64'(OutValid), 64'(0));
    check("async_rst_out", 64'(Out), 64'(0));
    check("async_rst_ready", 64'(InReady), 64'(1));
    @(negedge clk);
    @(negedge clk);
    Reset = 1'b0;
    #1;
    check("ready_after_release2", 64'(InReady), 64'(1));
    OutReady = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (OutValid) seen++;
    end
    check("no_stale", 64'(seen), 64'(0));
    send_one(1, "post_rst");

    // Streaming with random bubbles and random backpressure.
    n_sent  = 0;
    n_got   = 0;
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while (n_got < N_STR && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (stalled) check("stall_hold", 64'({OutValid, Out}), 64'({1'b1, held}));
      OutReady = 1'($urandom_range(0, 1));
      InValid  = (n_sent < N_STR) && ($urandom_range(0, 3) != 0);
      In       = pack_in(n_sent, n_sent + 500, n_sent + 1000, n_sent + 1500);
      #1;
      if (OutValid && OutReady) begin
        check("stream_data", 64'(Out), 64'(pack_out(n_got, n_got + 500, n_got + 1000, n_got + 1500)));
        n_got++;
      end
      stalled = OutValid && !OutReady;
      held    = Out;
      if (InValid && InReady) n_sent++;
    end
    check("stream_count", 64'(n_got), 64'(N_STR));
    InValid  = 1'b0;
    OutReady = 1'b1;
    repeat (4) @(negedge clk);
    check("stream_drained", 64'(OutValid), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
